// File: rtl/cs_address_sequencer_pkg.sv
// rtl/cs_address_sequencer_pkg.sv - shared mode encodings for the control-store address sequencer
package cs_address_sequencer_pkg;

   typedef enum logic [2:0] {
      MODE_NEXT   = 3'd0,
      MODE_JUMP   = 3'd1,
      MODE_DECODE = 3'd2,
      MODE_CJUMP  = 3'd3,
      MODE_CALL   = 3'd4,
      MODE_RETURN = 3'd5
   } cs_mode_e;

endpackage

// File: rtl/cs_return_stack.sv
// rtl/cs_return_stack.sv - LIFO return-address stack with occupancy pointer and full/empty status
module cs_return_stack #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 11
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] top,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0]    ptr;
   logic [AW-1:0]    top_idx;
   logic [WIDTH-1:0] mem [DEPTH];

   assign full    = (ptr == PW'(DEPTH));
   assign empty   = (ptr == '0);
   // Low bits wrap to DEPTH-1 when full, which is exactly the top slot.
   assign top_idx = ptr[AW-1:0] - AW'(1);
   assign top     = mem[top_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (push && !full) begin
         ptr <= ptr + PW'(1);
      end else if (pop && !empty) begin
         ptr <= ptr - PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem[ptr[AW-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/cs_address_sequencer.sv
// rtl/cs_address_sequencer.sv - micro-PC sequencer: next/jump/decode/conditional/call/return
module cs_address_sequencer
   import cs_address_sequencer_pkg::*;
#(
   parameter int Direction_BUS_WIDTH = 11,
   parameter int Decode_BUS_WIDTH    = 8,
   parameter int Condition_BUS_WIDTH = 4,
   parameter int Stack_DEPTH         = 4,
   parameter logic [Direction_BUS_WIDTH-1:0] Reset_VECTOR = '0,
   localparam int SEL_W = (Condition_BUS_WIDTH > 1) ? $clog2(Condition_BUS_WIDTH) : 1
) (
   input  logic                           CS_Sequencer_CLOCK_50,
   input  logic                           CS_Sequencer_RESET_InLow,
   input  logic                           CS_Sequencer_Stall_IN,
   input  logic [2:0]                     CS_Sequencer_Selection_IN,
   input  logic [Direction_BUS_WIDTH-1:0] CS_Sequencer_Jump_IN,
   input  logic [Decode_BUS_WIDTH-1:0]    CS_Sequencer_Decode_IN,
   input  logic [Condition_BUS_WIDTH-1:0] CS_Sequencer_Flags_IN,
   input  logic [SEL_W-1:0]               CS_Sequencer_CondSel_IN,
   input  logic                           CS_Sequencer_CondPol_IN,
   input  logic                           CS_Sequencer_ClearErr_IN,
   output logic [Direction_BUS_WIDTH-1:0] CS_Sequencer_Direccion_OUT,
   output logic                           CS_Sequencer_StackFull_OUT,
   output logic                           CS_Sequencer_StackEmpty_OUT,
   output logic                           CS_Sequencer_Overflow_OUT,
   output logic                           CS_Sequencer_Underflow_OUT
);

   localparam logic [SEL_W:0] COND_LIMIT = (SEL_W + 1)'(Condition_BUS_WIDTH);

   logic [Direction_BUS_WIDTH-1:0] pc;
   logic [Direction_BUS_WIDTH-1:0] next_pc;
   logic [Direction_BUS_WIDTH-1:0] inc_pc;
   logic [Direction_BUS_WIDTH-1:0] decode_pc;
   logic [Direction_BUS_WIDTH-1:0] stack_top;
   logic [Condition_BUS_WIDTH-1:0] flags_shifted;
   logic                           cond_taken;
   logic                           stack_push;
   logic                           stack_pop;
   logic                           stack_full;
   logic                           stack_empty;
   logic                           ovf_event;
   logic                           unf_event;
   logic                           ovf;
   logic                           unf;

   assign inc_pc        = pc + Direction_BUS_WIDTH'(1);
   assign flags_shifted = CS_Sequencer_Flags_IN >> CS_Sequencer_CondSel_IN;
   // An out-of-range flag index never takes the branch.
   assign cond_taken    = ({1'b0, CS_Sequencer_CondSel_IN} < COND_LIMIT) &&
                          (flags_shifted[0] == CS_Sequencer_CondPol_IN);

   always_comb begin
      decode_pc = '0;
      decode_pc[Direction_BUS_WIDTH-1]    = 1'b1;
      decode_pc[Decode_BUS_WIDTH+1:2]     = CS_Sequencer_Decode_IN;
   end

   always_comb begin
      next_pc    = pc;
      stack_push = 1'b0;
      stack_pop  = 1'b0;
      ovf_event  = 1'b0;
      unf_event  = 1'b0;
      if (!CS_Sequencer_Stall_IN) begin
         case (CS_Sequencer_Selection_IN)
            MODE_JUMP:   next_pc = CS_Sequencer_Jump_IN;
            MODE_DECODE: next_pc = decode_pc;
            MODE_CJUMP:  next_pc = cond_taken ? CS_Sequencer_Jump_IN : inc_pc;
            MODE_CALL: begin
               if (stack_full) begin
                  ovf_event = 1'b1;
               end else begin
                  stack_push = 1'b1;
                  next_pc    = CS_Sequencer_Jump_IN;
               end
            end
            MODE_RETURN: begin
               if (stack_empty) begin
                  unf_event = 1'b1;
               end else begin
                  stack_pop = 1'b1;
                  next_pc   = stack_top;
               end
            end
            default:     next_pc = inc_pc;
         endcase
      end
   end

   always_ff @(posedge CS_Sequencer_CLOCK_50 or negedge CS_Sequencer_RESET_InLow) begin
      if (!CS_Sequencer_RESET_InLow) begin
         pc  <= Reset_VECTOR;
         ovf <= 1'b0;
         unf <= 1'b0;
      end else if (!CS_Sequencer_Stall_IN) begin
         pc  <= next_pc;
         // A new error in the same cycle as the clear wins.
         ovf <= (ovf && !CS_Sequencer_ClearErr_IN) || ovf_event;
         unf <= (unf && !CS_Sequencer_ClearErr_IN) || unf_event;
      end
   end

   cs_return_stack #(
      .DEPTH (Stack_DEPTH),
      .WIDTH (Direction_BUS_WIDTH)
   ) u_return_stack (
      .clk       (CS_Sequencer_CLOCK_50),
      .rst_n     (CS_Sequencer_RESET_InLow),
      .push      (stack_push),
      .pop       (stack_pop),
      .push_data (inc_pc),
      .top       (stack_top),
      .full      (stack_full),
      .empty     (stack_empty)
   );

   assign CS_Sequencer_Direccion_OUT  = pc;
   assign CS_Sequencer_StackFull_OUT  = stack_full;
   assign CS_Sequencer_StackEmpty_OUT = stack_empty;
   assign CS_Sequencer_Overflow_OUT   = ovf;
   assign CS_Sequencer_Underflow_OUT  = unf;

endmodule
